// File: rtl/quad_exp_seq_pkg.sv
// Shared constants, FSM encoding and the GF(2^233) squaring helper for the
// quad_exp_seq block. Field polynomial: f(x) = x^233 + x^74 + 1.
package quad_exp_seq_pkg;

  localparam int unsigned M      = 233;  // field width
  localparam int unsigned MAXSEL = 14;   // deepest quadblk tap
  localparam int unsigned KW     = 16;   // width of the k request field
  localparam int unsigned SELW   = 4;    // width of the quadblk tap select
  localparam int unsigned TAP    = 74;   // middle term of f(x)

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Squaring spreads bits to even positions, then folds every term at or above
  // x^233 back down using x^233 = x^74 + 1. Folding runs from the top down so
  // that terms which land above x^232 again are folded later in the loop.
  function automatic logic [M-1:0] gf_sqr(input logic [M-1:0] a);
    logic [2*M-2:0] c;
    c = '0;
    for (int i = 0; i < int'(M); i++) begin
      c[2*i] = a[i];
    end
    for (int i = 2*int'(M)-2; i >= int'(M); i--) begin
      if (c[i]) begin
        c[i-int'(M)]          = ~c[i-int'(M)];
        c[i-int'(M)+int'(TAP)] = ~c[i-int'(M)+int'(TAP)];
      end
    end
    return c[M-1:0];
  endfunction

endpackage

// File: rtl/quad_exp_seq_if.sv
// Request/response bundle for quad_exp_seq.
//   start  : request strobe (sampled only while busy is low)
//   k      : number of quadrings to apply
//   a_in   : field operand
//   busy   : computation in progress
//   done   : one-cycle completion pulse
//   d_out  : result, held until the next accepted start
interface quad_exp_seq_if;
  import quad_exp_seq_pkg::*;

  logic          start;
  logic [KW-1:0] k;
  logic [M-1:0]  a_in;
  logic          busy;
  logic          done;
  logic [M-1:0]  d_out;

  modport master (
    output start, k, a_in,
    input  busy, done, d_out
  );

  modport slave (
    input  start, k, a_in,
    output busy, done, d_out
  );

endinterface

// File: rtl/quadblk.sv
// Combinational chain of MAXSEL quadrings in GF(2^233); sel_i picks how many
// are applied (1..MAXSEL). Out-of-range selects fall back to one quadring.
//   a_i   : field operand
//   sel_i : number of quadrings
//   d_o   : a_i^(4^sel_i)
module quadblk
  import quad_exp_seq_pkg::*;
(
  input  logic [M-1:0]    a_i,
  input  logic [SELW-1:0] sel_i,
  output logic [M-1:0]    d_o
);

  logic [M-1:0] tap [MAXSEL+1];

  assign tap[0] = a_i;

  for (genvar i = 1; i <= int'(MAXSEL); i++) begin : g_quad
    assign tap[i] = gf_sqr(gf_sqr(tap[i-1]));
  end

  always_comb begin
    d_o = tap[1];
    for (int i = 1; i <= int'(MAXSEL); i++) begin
      if (sel_i == SELW'(i)) begin
        d_o = tap[i];
      end
    end
  end

endmodule

// File: rtl/quad_exp_seq.sv
// Iterative sequencer computing d = a^(4^k) in GF(2^233) for k up to 65535.
// Each RUN cycle pushes the accumulator through up to MAXSEL quadrings.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : request/response bundle (slave side)
module quad_exp_seq
  import quad_exp_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  quad_exp_seq_if.slave bus
);

  state_e          state_q, state_d;
  logic [M-1:0]    acc_q, acc_d;
  logic [KW-1:0]   rem_q, rem_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [M-1:0]    dout_q, dout_d;

  logic [SELW-1:0] sel;
  logic            last_pass;
  logic [M-1:0]    quad_out;

  // Passes consume min(rem, MAXSEL); rem never underflows since sel <= rem.
  assign last_pass = (rem_q <= KW'(MAXSEL));

  always_comb begin
    sel = SELW'(1);
    if (state_q == StRun) begin
      sel = last_pass ? rem_q[SELW-1:0] : SELW'(MAXSEL);
    end
  end

  quadblk u_quadblk (
    .a_i   (acc_q),
    .sel_i (sel),
    .d_o   (quad_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.start && (bus.k != '0)) state_d = StRun;
      StRun:  if (last_pass) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath / output next values.
  always_comb begin
    acc_d  = acc_q;
    rem_d  = rem_q;
    busy_d = busy_q;
    done_d = 1'b0;
    dout_d = dout_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.k == '0) begin
            dout_d = bus.a_in;
            done_d = 1'b1;
          end else begin
            acc_d  = bus.a_in;
            rem_d  = bus.k;
            busy_d = 1'b1;
          end
        end
      end
      StRun: begin
        acc_d = quad_out;
        rem_d = rem_q - KW'(sel);
        if (last_pass) begin
          dout_d = quad_out;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      rem_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dout_q <= '0;
    end else begin
      acc_q  <= acc_d;
      rem_q  <= rem_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dout_q <= dout_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.d_out = dout_q;

endmodule

// File: tb/tb_quad_exp_seq.sv
module tb_quad_exp_seq;
  localparam int W = 233;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [W-1:0] exp_q [$];

  quad_exp_seq_if bus ();

  quad_exp_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: plain shift-and-add multiplication mod x^233+x^74+1.
  function automatic logic [W-1:0] mulx(input logic [W-1:0] a);
    logic [W-1:0] r;
    r = a << 1;
    if (a[W-1]) begin
      r[0]  = ~r[0];
      r[74] = ~r[74];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] gmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int i = W-1; i >= 0; i--) begin
      r = mulx(r);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] quad_n(input logic [W-1:0] a, input int n);
    logic [W-1:0] r;
    r = a;
    for (int i = 0; i < 2*n; i++) r = gmul(r, r);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_fe();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s obs=empty-scoreboard exp=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, bus.d_out, e);
    end
  endtask

  // Issue one request from a negedge, then wait for done; checks latency,
  // busy duration, the result and that done falls again.
  task automatic run_op(input string tag, input int kk, input logic [W-1:0] aa,
                        input int exp_edges, input int exp_busy);
    int edges;
    int busy_n;
    exp_q.push_back(quad_n(aa, kk));
    bus.start = 1'b1;
    bus.k     = 16'(kk);
    bus.a_in  = aa;
    @(negedge clk);
    bus.start = 1'b0;
    bus.k     = 16'($urandom);
    bus.a_in  = rand_fe();
    edges  = 1;
    busy_n = 0;
    while (!bus.done && edges < exp_edges + 4) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      edges++;
    end
    chk({tag, "_lat"}, W'(edges), W'(exp_edges));
    chk({tag, "_busy"}, W'(busy_n), W'(exp_busy));
    chk({tag, "_busy_at_done"}, W'(bus.busy), W'(0));
    pop_chk({tag, "_dout"});
    @(negedge clk);
    chk({tag, "_done_fall"}, W'(bus.done), W'(0));
  endtask

  initial begin
    logic [W-1:0] x, a, r;
    int           npulse;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.k     = '0;
    bus.a_in  = '0;
    x         = '0;
    x[1]      = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_done", W'(bus.done), W'(0));
    chk("rst_dout", bus.d_out, W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // k=0: pass-through in one edge, busy never raised.
    run_op("k0", 0, W'(16'h1234), 1, 0);
    chk("k0_hold", bus.d_out, W'(16'h1234));

    // x^4 and x^64.
    run_op("k1", 1, x, 2, 1);
    r = '0;
    r[4] = 1'b1;
    chk("k1_bit4", bus.d_out, r);
    run_op("k3", 3, x, 2, 1);
    r = '0;
    r[64] = 1'b1;
    chk("k3_bit64", bus.d_out, r);

    // Pass-count boundary around MAXSEL.
    run_op("k14", 14, rand_fe(), 2, 1);
    run_op("k15", 15, rand_fe(), 3, 2);

    // a^(2^466) = a.
    a = rand_fe();
    run_op("k233", 233, a, 18, 17);
    chk("k233_ident", bus.d_out, a);

    // start held high with k=28; inputs are scrambled while busy.
    for (int i = 0; i < 3; i++) begin
      a = rand_fe();
      exp_q.push_back(quad_n(a, 28));
      bus.start = 1'b1;
      bus.k     = 16'd28;
      bus.a_in  = a;
      @(negedge clk);
      bus.k    = 16'($urandom);
      bus.a_in = rand_fe();
      chk($sformatf("hold%0d_done_c1", i), W'(bus.done), W'(0));
      @(negedge clk);
      chk($sformatf("hold%0d_done_c2", i), W'(bus.done), W'(0));
      @(negedge clk);
      chk($sformatf("hold%0d_done_c3", i), W'(bus.done), W'(1));
      pop_chk($sformatf("hold%0d_dout", i));
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk("hold_done_fall", W'(bus.done), W'(0));

    // Reset mid-run aborts without a done pulse.
    bus.start = 1'b1;
    bus.k     = 16'd1000;
    bus.a_in  = rand_fe();
    @(negedge clk);
    bus.start = 1'b0;
    chk("abort_busy", W'(bus.busy), W'(1));
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_rst_busy", W'(bus.busy), W'(0));
    chk("abort_rst_done", W'(bus.done), W'(0));
    chk("abort_rst_dout", bus.d_out, W'(0));
    npulse = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done) npulse++;
    end
    chk("abort_no_done", W'(npulse), W'(0));
    chk("sb_empty", W'(exp_q.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
